// File: rtl/mc_native_req_queue_if.sv
// Command channel between a requester and a consumer: one write/read command with data and byte mask.
// The master drives the command, and the slave accepts it with ready.
interface mc_native_req_queue_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 256
);
    logic                  valid;
    logic                  ready;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wmask;

    modport master (output valid, we, addr, wdata, wmask, input ready);
    modport slave  (input valid, we, addr, wdata, wmask, output ready);
endinterface

// File: rtl/mc_native_req_queue.sv
// Per-port request queue for one native port. Reads are throttled by an outstanding-read limit. MC_NATIVE_Q_STATS_EN adds o_hwm/o_push_cnt.
// Latency: push to offer is 1 cycle, and read return is 1 cycle. Backpressure: usr ready is low when full or clearing; read return has no backpressure.
module mc_native_req_queue #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 256,
    parameter int DEPTH      = 8,
    parameter int MAX_RD_OUT = 16,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_fifo_clr,
    mc_native_req_queue_if.slave     usr,
    mc_native_req_queue_if.master    nat,
    input  logic                     nat_rdata_valid,
    input  logic [DATA_W-1:0]        nat_rdata,
    output logic                     usr_rdata_valid,
    output logic [DATA_W-1:0]        usr_rdata,
    output logic [LVL_W-1:0]         o_level,
    output logic [7:0]               o_rd_outstanding,
    output logic                     o_err
`ifdef MC_NATIVE_Q_STATS_EN
    ,
    output logic [LVL_W-1:0]         o_hwm,
    output logic [31:0]              o_push_cnt
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wmask;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [7:0]         rd_out;
    logic               push, pop, rd_pop, rd_room;

    assign head      = mem[rd_ptr];
    assign usr.ready = (level != LVL_W'(DEPTH)) & ~i_fifo_clr;
    assign rd_room   = rd_out < 8'(MAX_RD_OUT);
    assign nat.valid = (level != '0) & (head.we | rd_room);
    assign nat.we    = head.we;
    assign nat.addr  = head.addr;
    assign nat.wdata = head.wdata;
    assign nat.wmask = head.wmask;

    assign push   = usr.valid & usr.ready;
    assign pop    = nat.valid & nat.ready;
    assign rd_pop = pop & ~head.we;

    assign o_level          = level;
    assign o_rd_outstanding = rd_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= {usr.we, usr.addr, usr.wdata, usr.wmask};
        end
    end

    // A flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || i_fifo_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // A read the native port has accepted will return data, so it is counted even during a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_out          <= '0;
            o_err           <= 1'b0;
            usr_rdata_valid <= 1'b0;
            usr_rdata       <= '0;
        end else begin
            usr_rdata_valid <= nat_rdata_valid;
            usr_rdata       <= nat_rdata;
            if (nat_rdata_valid && rd_out == '0) o_err <= 1'b1;
            if (rd_pop && !nat_rdata_valid)
                rd_out <= rd_out + 1'b1;
            else if (!rd_pop && nat_rdata_valid && rd_out != '0)
                rd_out <= rd_out - 1'b1;
        end
    end

`ifdef MC_NATIVE_Q_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_hwm      <= '0;
            o_push_cnt <= '0;
        end else begin
            if (level > o_hwm) o_hwm <= level;
            if (push) o_push_cnt <= o_push_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_native_req_queue.sv
// Bench for mc_native_req_queue. Expected native commands and read returns are queued at issue time and checked by a monitor.
// Queue state is also checked directly at chosen cycles.
module tb_mc_native_req_queue;
    localparam int AW    = 28;
    localparam int DW    = 64;
    localparam int MW    = DW / 8;
    localparam int DEPTH = 8;
    localparam int MRO   = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_fifo_clr = 1'b0;
    logic          nat_rdata_valid = 1'b0;
    logic [DW-1:0] nat_rdata = '0;
    logic          usr_rdata_valid;
    logic [DW-1:0] usr_rdata;
    logic [LW-1:0] o_level;
    logic [7:0]    o_rd_outstanding;
    logic          o_err;
`ifdef MC_NATIVE_Q_STATS_EN
    logic [LW-1:0] o_hwm;
    logic [31:0]   o_push_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [127:0]  cmd_q [$];
    logic [DW-1:0] rd_q  [$];

    mc_native_req_queue_if #(.ADDR_W(AW), .DATA_W(DW)) usr_if ();
    mc_native_req_queue_if #(.ADDR_W(AW), .DATA_W(DW)) nat_if ();

    mc_native_req_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .MAX_RD_OUT(MRO)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_fifo_clr       (i_fifo_clr),
        .usr              (usr_if),
        .nat              (nat_if),
        .nat_rdata_valid  (nat_rdata_valid),
        .nat_rdata        (nat_rdata),
        .usr_rdata_valid  (usr_rdata_valid),
        .usr_rdata        (usr_rdata),
        .o_level          (o_level),
        .o_rd_outstanding (o_rd_outstanding),
        .o_err            (o_err)
`ifdef MC_NATIVE_Q_STATS_EN
        ,
        .o_hwm            (o_hwm),
        .o_push_cnt       (o_push_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pack_cmd(logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        return 128'({we, a, d, m});
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(logic we, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        bit ok = 0;
        usr_if.valid = 1'b1;
        usr_if.we    = we;
        usr_if.addr  = a;
        usr_if.wdata = d;
        usr_if.wmask = m;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (usr_if.ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("push_timeout", 0, 1);
            #1;
        end else begin
            @(posedge clk);
            cmd_q.push_back(pack_cmd(we, a, d, m));
            #1;
        end
        usr_if.valid = 1'b0;
    endtask

    task automatic rdata_pulse(logic [DW-1:0] d);
        nat_rdata_valid = 1'b1;
        nat_rdata       = d;
        rd_q.push_back(d);
        step();
        nat_rdata_valid = 1'b0;
    endtask

    task automatic wait_empty(string name);
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_level == '0) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    // Monitor: every native handshake and every read return is matched against the expected queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (nat_if.valid && nat_if.ready) begin
                if (cmd_q.size() == 0)
                    check("nat_pop_unexpected", pack_cmd(nat_if.we, nat_if.addr, nat_if.wdata, nat_if.wmask), 0);
                else
                    check("nat_cmd", pack_cmd(nat_if.we, nat_if.addr, nat_if.wdata, nat_if.wmask), cmd_q.pop_front());
            end
            if (usr_rdata_valid) begin
                if (rd_q.size() == 0) check("rdata_unexpected", usr_rdata, 0);
                else                  check("usr_rdata", usr_rdata, rd_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        usr_if.valid = 1'b0; usr_if.we = 1'b0; usr_if.addr = '0; usr_if.wdata = '0; usr_if.wmask = '0;
        nat_if.ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_level", o_level, 0);
        check("rst_usr_ready", usr_if.ready, 1);
        check("rst_nat_valid", nat_if.valid, 0);
        check("rst_rd_out", o_rd_outstanding, 0);
        check("rst_err", o_err, 0);
        check("rst_rdata_valid", usr_rdata_valid, 0);
        step();

        // A single read into an empty queue is offered the cycle after the push.
        nat_if.ready = 1'b1;
        push_cmd(1'b0, 28'h100, '0, '0);
        @(negedge clk);
        check("t1_valid_next", nat_if.valid, 1);
        check("t1_level_1", o_level, 1);
        step();
        @(negedge clk);
        check("t1_level_0", o_level, 0);
        check("t1_rd_out", o_rd_outstanding, 1);
        step();
        nat_if.ready = 1'b0;
        rdata_pulse(64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        check("t1_rdata_lat", usr_rdata_valid, 1);
        check("t1_rd_out_0", o_rd_outstanding, 0);
        step();

        // Fill with 8 writes, then drain them in order.
        for (int i = 0; i < 8; i++)
            push_cmd(1'b1, AW'(28'h400 + i), {32'hA5A5_0000 + 32'(i), 32'h1234_0000 + 32'(i)}, MW'(8'h01 << i));
        @(negedge clk);
        check("t2_full_ready", usr_if.ready, 0);
        check("t2_full_level", o_level, 8);
        check("t2_full_valid", nat_if.valid, 1);
        step();
        nat_if.ready = 1'b1;
        wait_empty("t2_drain");
        check("t2_all_popped", cmd_q.size(), 0);
        step();
        nat_if.ready = 1'b0;

        // Outstanding-read limit of 2 holds back the third read.
        for (int i = 0; i < 3; i++) push_cmd(1'b0, AW'(28'h200 + i), '0, '0);
        nat_if.ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_level_1", o_level, 1);
        check("t3_rd_out_2", o_rd_outstanding, 2);
        check("t3_valid_blocked", nat_if.valid, 0);
        step();
        rdata_pulse(64'h0000_0000_0000_0A02);
        @(negedge clk);
        check("t3_third_offered", nat_if.valid, 1);
        step();
        @(negedge clk);
        check("t3_level_0", o_level, 0);
        check("t3_rd_out_again_2", o_rd_outstanding, 2);
        step();
        nat_if.ready = 1'b0;
        rdata_pulse(64'h0000_0000_0000_0B01);
        rdata_pulse(64'h0000_0000_0000_0B02);
        @(negedge clk);
        check("t3_rd_out_0", o_rd_outstanding, 0);
        step();

        // A same-cycle read pop and data return leave the counter unchanged.
        nat_if.ready = 1'b1;
        push_cmd(1'b0, 28'h300, '0, '0);
        step();
        nat_if.ready = 1'b0;
        @(negedge clk);
        check("t4_rd_out_1", o_rd_outstanding, 1);
        step();
        push_cmd(1'b0, 28'h301, '0, '0);
        nat_if.ready    = 1'b1;
        nat_rdata_valid = 1'b1;
        nat_rdata       = 64'h0000_0000_0000_0C01;
        rd_q.push_back(64'h0000_0000_0000_0C01);
        step();
        nat_if.ready    = 1'b0;
        nat_rdata_valid = 1'b0;
        @(negedge clk);
        check("t4_same_cycle_rd_out", o_rd_outstanding, 1);
        check("t4_level_0", o_level, 0);
        step();
        rdata_pulse(64'h0000_0000_0000_0C02);
        rdata_pulse(64'h0000_0000_0000_0C03);
        @(negedge clk);
        check("t4_err_set", o_err, 1);
        check("t4_rd_out_stays_0", o_rd_outstanding, 0);
        step();

        // A flush with a concurrent push empties the queue and leaves the read counter alone.
        nat_if.ready = 1'b1;
        push_cmd(1'b0, 28'h500, '0, '0);
        step();
        nat_if.ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(i[0], AW'(28'h600 + i), 64'(i), MW'(i));
        @(negedge clk);
        check("t5_level_5", o_level, 5);
        check("t5_rd_out_1", o_rd_outstanding, 1);
        step();
        i_fifo_clr   = 1'b1;
        usr_if.valid = 1'b1; usr_if.we = 1'b1; usr_if.addr = 28'h700;
        @(negedge clk);
        check("t5_ready_in_clr", usr_if.ready, 0);
        step();
        i_fifo_clr   = 1'b0;
        usr_if.valid = 1'b0;
        cmd_q.delete();
        @(negedge clk);
        check("t5_clr_level", o_level, 0);
        check("t5_clr_valid", nat_if.valid, 0);
        check("t5_clr_rd_out", o_rd_outstanding, 1);
        check("t5_err_kept", o_err, 1);
        step();
        rdata_pulse(64'h0000_0000_0000_0D01);
        @(negedge clk);
        check("t5_rd_out_0", o_rd_outstanding, 0);
        step();
        nat_if.ready = 1'b1;
        push_cmd(1'b1, 28'h800, 64'h0123_4567_89AB_CDEF, 8'h5A);
        repeat (3) @(negedge clk);
        check("t5_post_clr_level", o_level, 0);
        check("t5_post_clr_popped", cmd_q.size(), 0);
        step();
        nat_if.ready = 1'b0;

`ifdef MC_NATIVE_Q_STATS_EN
        rst = 1'b1;
        cmd_q.delete();
        rd_q.delete();
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("st_rst_hwm", o_hwm, 0);
        check("st_rst_cnt", o_push_cnt, 0);
        step();
        for (int i = 0; i < 6; i++) push_cmd(1'b1, AW'(28'h900 + i), 64'(i), '0);
        step();
        nat_if.ready = 1'b1;
        wait_empty("st_drain");
        step();
        nat_if.ready = 1'b0;
        i_fifo_clr   = 1'b1;
        step();
        i_fifo_clr   = 1'b0;
        @(negedge clk);
        check("st_hwm", o_hwm, 6);
        check("st_push_cnt", o_push_cnt, 6);
`endif

        repeat (3) @(negedge clk);
        check("rd_q_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
